// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared constants, FSM state encoding and saturating level helpers for the
// LED brightness stage (led_pwm_dimmer and its key_debounce sub-module).
//
// Contents:
//   LVL_W / LVL_MAX  : brightness level width and ceiling (16 levels)
//   PWM_W            : PWM counter / duty width (256 steps)
//   breath_state_e   : breathing FSM states (MANUAL, BREATH_UP, BREATH_DN)
//   lvl_inc/lvl_dec  : level step with saturation at LVL_MAX / 0
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

  localparam int LVL_W   = 4;
  localparam int LVL_MAX = 15;
  localparam int PWM_W   = 8;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    BREATH_UP = 2'd1,
    BREATH_DN = 2'd2
  } breath_state_e;

  // One level brighter, holding at the top level
  function automatic logic [LVL_W-1:0] lvl_inc(input logic [LVL_W-1:0] lvl);
    return (lvl == LVL_W'(LVL_MAX)) ? lvl : lvl + LVL_W'(1);
  endfunction

  // One level dimmer, holding at zero
  function automatic logic [LVL_W-1:0] lvl_dec(input logic [LVL_W-1:0] lvl);
    return (lvl == '0) ? lvl : lvl - LVL_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low push-button and debounces it. The debounced
// state only follows the synchronised input once that input has held its new
// value for DEB_CYC consecutive cycles; any bounce restarts the count.
// A debounced press (released -> pressed) yields a single-cycle pulse;
// releasing the key produces nothing.
//
// Parameters:
//   DEB_CYC   : number of stable cycles required before the state changes
// Ports:
//   sys_clk   : in  system clock, rising edge
//   rst_n     : in  asynchronous active-low reset (state -> released)
//   key_n     : in  raw key, active-low, asynchronous to sys_clk
//   key_press : out one-cycle pulse on a debounced press
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_press
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_done;

  assign w_differs = (r_sync2 != r_stable);
  // The new value has been seen for the last required cycle in this cycle
  assign w_done    = w_differs && (r_cnt == CNT_W'(DEB_CYC - 1));

  // Two-flop synchroniser; idles at "released" (high)
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter: runs while the synchronised input disagrees with the
  // debounced state and is cleared whenever they agree again (bounce)
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else if (!w_differs) begin
      r_cnt    <= '0;
    end else if (w_done) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Pulse coincides with the cycle in which the debounced state falls
  assign key_press = w_done && !r_sync2;

endmodule

// File: rtl/led_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// led_pwm_dimmer
// Brightness stage behind the LED blink generator. The 8-bit blink pattern is
// gated by a 256-step PWM whose duty is {level, level}. Two debounced keys
// step the 16-level brightness up/down (saturating).
//
// Optional feature macro: LED_BREATH_EN
//   defined   : adds a breathing FSM (MANUAL / BREATH_UP / BREATH_DN) toggled
//               by key_mode, stepping the level every BREATH_STEP_MS ms
//   undefined : manual control only; key_mode is not used
//
// Parameters:
//   CLK_FREQ, PWM_FREQ : PWM prescaler DIV = CLK_FREQ/(PWM_FREQ*256), >= 1
//   DEB_MS             : key debounce time in ms
//   INIT_LEVEL         : brightness level after reset (0..15)
//   BREATH_STEP_MS     : breathing step interval in ms
// Ports:
//   sys_clk  : in  system clock, rising edge
//   rst_n    : in  asynchronous active-low reset
//   led_in   : in  [7:0] blink pattern, 1 = lit
//   key_up   : in  raw brighter key, active-low
//   key_dn   : in  raw dimmer key, active-low
//   key_mode : in  raw breathing mode key, active-low
//   led_out  : out [7:0] registered gated LED drive, 1 = lit
//   level    : out [3:0] current brightness level
// -----------------------------------------------------------------------------
module led_pwm_dimmer
  import led_ctrl_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int PWM_FREQ       = 1_000,
  parameter int DEB_MS         = 20,
  parameter int INIT_LEVEL     = 8,
  parameter int BREATH_STEP_MS = 62
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [7:0]       led_in,
  input  logic             key_up,
  input  logic             key_dn,
  input  logic             key_mode,
  output logic [7:0]       led_out,
  output logic [LVL_W-1:0] level
);

  localparam int DIV     = CLK_FREQ / (PWM_FREQ * 256);
  localparam int DEB_CYC = CLK_FREQ / 1000 * DEB_MS;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic             w_upPress;
  logic             w_dnPress;
  logic             w_tick;
  logic             w_pwmOn;
  logic [PRE_W-1:0] r_presc;
  logic [PWM_W-1:0] r_pwmCnt;
  logic [PWM_W-1:0] r_duty;
  logic [7:0]       r_ledOut;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_levelNext;
  logic [LVL_W-1:0] w_manualLevel;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_keyUp (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_n     (key_up),
    .key_press (w_upPress)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_keyDn (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_n     (key_dn),
    .key_press (w_dnPress)
  );

  // Prescaler: one PWM tick every DIV clocks
  assign w_tick = (r_presc == PRE_W'(DIV - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRE_W'(1);
  end

  // Duty only reloads as the counter wraps so a level change never cuts a
  // PWM period short or stretches it
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwmCnt <= '0;
      r_duty   <= '0;
    end else if (w_tick) begin
      r_pwmCnt <= r_pwmCnt + PWM_W'(1);
      if (r_pwmCnt == '1) r_duty <= {r_level, r_level};
    end
  end

  // Full duty must stay lit for all 256 counts, not just 255
  assign w_pwmOn = (r_pwmCnt < r_duty) || (r_duty == '1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_ledOut <= '0;
    else        r_ledOut <= led_in & {8{w_pwmOn}};
  end

  assign led_out = r_ledOut;

  // Manual key stepping; both keys together cancel out
  always_comb begin
    w_manualLevel = r_level;
    if (w_upPress && !w_dnPress)      w_manualLevel = lvl_inc(r_level);
    else if (w_dnPress && !w_upPress) w_manualLevel = lvl_dec(r_level);
  end

`ifdef LED_BREATH_EN
  localparam int STEP_CYC = CLK_FREQ / 1000 * BREATH_STEP_MS;
  localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  breath_state_e     r_state;
  breath_state_e     w_stateNext;
  logic              w_modePress;
  logic              w_stepExpire;
  logic [STEP_W-1:0] r_stepCnt;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_keyMode (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_n     (key_mode),
    .key_press (w_modePress)
  );

  assign w_stepExpire = (r_stepCnt == STEP_W'(STEP_CYC - 1));

  // Step timer is held clear in MANUAL so breathing always starts with a
  // full interval
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                                r_stepCnt <= '0;
    else if (r_state == MANUAL || w_stepExpire) r_stepCnt <= '0;
    else                                       r_stepCnt <= r_stepCnt + STEP_W'(1);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= MANUAL;
    else        r_state <= w_stateNext;
  end

  // A mode press always takes precedence over a coincident step expiry
  always_comb begin
    w_stateNext = r_state;
    w_levelNext = r_level;
    case (r_state)
      MANUAL: begin
        if (w_modePress) w_stateNext = BREATH_UP;
        else             w_levelNext = w_manualLevel;
      end
      BREATH_UP: begin
        if (w_modePress) begin
          w_stateNext = MANUAL;
        end else if (w_stepExpire) begin
          w_levelNext = lvl_inc(r_level);
          if (w_levelNext == LVL_W'(LVL_MAX)) w_stateNext = BREATH_DN;
        end
      end
      BREATH_DN: begin
        if (w_modePress) begin
          w_stateNext = MANUAL;
        end else if (w_stepExpire) begin
          w_levelNext = lvl_dec(r_level);
          if (w_levelNext == '0) w_stateNext = BREATH_UP;
        end
      end
      default: w_stateNext = MANUAL;
    endcase
  end
`else
  logic        w_unusedMode;
  logic [31:0] w_unusedStep;

  assign w_unusedMode = key_mode;
  assign w_unusedStep = 32'(BREATH_STEP_MS);
  assign w_levelNext  = w_manualLevel;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_level <= LVL_W'(INIT_LEVEL);
    else        r_level <= w_levelNext;
  end

  assign level = r_level;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_dimmer
// Self-checking bench for led_pwm_dimmer with DIV = 1 and DEB_CYC = 256.
// Breathing scenario is built only when LED_BREATH_EN is defined.
// -----------------------------------------------------------------------------
module tb_led_pwm_dimmer;

  localparam int DEB  = 256;
  localparam int HOLD = DEB + 20;

  logic       sysClk = 1'b0;
  logic       rstN;
  logic [7:0] ledIn;
  logic       keyUp;
  logic       keyDn;
  logic       keyMode;
  logic [7:0] ledOut;
  logic [3:0] level;

  int errCount   = 0;
  int checkCount = 0;
  int expLevel;

  logic [7:0] sbQ[$];

  typedef struct {
    logic [7:0] ledIn;
    bit         fullPhase;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[10];

  // 100 MHz bench clock; the DUT only sees cycles
  always #5 sysClk = ~sysClk;

  led_pwm_dimmer #(
    .CLK_FREQ       (256_000),
    .PWM_FREQ       (1000),
    .DEB_MS         (1),
    .INIT_LEVEL     (8),
    .BREATH_STEP_MS (1)
  ) dut (
    .sys_clk  (sysClk),
    .rst_n    (rstN),
    .led_in   (ledIn),
    .key_up   (keyUp),
    .key_dn   (keyDn),
    .key_mode (keyMode),
    .led_out  (ledOut),
    .level    (level)
  );

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] expOut);
    ledIn = v;
    sbQ.push_back(expOut);
  endtask

  task automatic checkScoreboard(input string name);
    logic [7:0] expOut;
    if (sbQ.size() == 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s: actual=%0d expected=queued entry", name, ledOut);
    end else begin
      expOut = sbQ.pop_front();
      checkOutput(name, int'(ledOut), int'(expOut));
    end
  endtask

  // which: 0 up, 1 down, 2 mode, 3 up+down together
  task automatic pressKey(input int which, input int times);
    for (int t = 0; t < times; t++) begin
      if (which == 0 || which == 3) keyUp = 1'b0;
      if (which == 1 || which == 3) keyDn = 1'b0;
      if (which == 2) keyMode = 1'b0;
      tick(HOLD);
      keyUp   = 1'b1;
      keyDn   = 1'b1;
      keyMode = 1'b1;
      tick(HOLD);
      if (which == 0 && expLevel < 15) expLevel++;
      if (which == 1 && expLevel > 0)  expLevel--;
    end
  endtask

  task automatic runTable(input bit fullPhase, input string name);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].fullPhase == fullPhase) begin
        applyStimulus(vecs[i].ledIn, vecs[i].expOut);
        tick(1);
        checkScoreboard(name);
      end
    end
    ledIn = 8'hFF;
  endtask

  initial begin
    int  onCount;
    int  cntA;
    int  cntB;
    bit  found;
    logic [7:0] prevOut;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C};
    vecs[2] = '{8'h01, 1'b1, 8'h01};
    vecs[3] = '{8'h80, 1'b1, 8'h80};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF};
    vecs[5] = '{8'h00, 1'b1, 8'h00};
    vecs[6] = '{8'hFF, 1'b0, 8'h00};
    vecs[7] = '{8'h5A, 1'b0, 8'h00};
    vecs[8] = '{8'hC3, 1'b0, 8'h00};
    vecs[9] = '{8'h7E, 1'b0, 8'h00};

    rstN     = 1'b0;
    ledIn    = 8'hFF;
    keyUp    = 1'b1;
    keyDn    = 1'b1;
    keyMode  = 1'b1;
    expLevel = 8;

    // Reset, then reset again mid-period while the LEDs are lit
    tick(3);
    rstN = 1'b1;
    tick(300);
    checkOutput("litBeforeReset", int'(ledOut), 8'hFF);
    rstN = 1'b0;
    #1;
    checkOutput("resetLedOut", int'(ledOut), 0);
    checkOutput("resetLevel", int'(level), 8);
    tick(2);
    rstN = 1'b1;

    onCount = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (ledOut != 8'h00) onCount++;
    end
    checkOutput("firstPeriodOn", onCount, 0);
    for (int p = 0; p < 2; p++) begin
      onCount = 0;
      for (int i = 0; i < 256; i++) begin
        tick(1);
        if (ledOut == 8'hFF) onCount++;
        if (i == 135) checkOutput("lastOnCycle", int'(ledOut), 8'hFF);
        if (i == 136) checkOutput("firstOffCycle", int'(ledOut), 0);
      end
      checkOutput("periodOnLevel8", onCount, 136);
    end

    // Bouncing key: ten 100-cycle segments starting low, then held low
    for (int s = 0; s < 10; s++) begin
      keyUp = (s % 2 == 0) ? 1'b0 : 1'b1;
      tick(100);
    end
    keyUp = 1'b0;
    tick(257);
    checkOutput("bounceBefore", int'(level), 8);
    tick(1);
    checkOutput("bounceStep", int'(level), 9);
    tick(20);
    keyUp = 1'b1;
    tick(HOLD);
    checkOutput("bounceRelease", int'(level), 9);
    expLevel = 9;

    // Saturate high; output must track the pattern exactly
    pressKey(0, 10);
    checkOutput("satHighLevel", int'(level), expLevel);
    checkOutput("satHighModel", expLevel, 15);
    tick(260);
    onCount = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (ledOut == 8'hFF) onCount++;
    end
    checkOutput("fullOnPeriod", onCount, 256);
    runTable(1'b1, "vecFull");

    // Saturate low; output must stay dark whatever the pattern
    pressKey(1, 20);
    checkOutput("satLowLevel", int'(level), 0);
    tick(260);
    runTable(1'b0, "vecZero");

    // Both keys pressed in the same cycle leave the level alone
    pressKey(0, 5);
    checkOutput("beforeBoth", int'(level), 5);
    pressKey(3, 1);
    checkOutput("simultaneous", int'(level), 5);

    // Level 11 -> 12 while pwm_cnt is 100: current period keeps 0xBB
    pressKey(1, 1);
    pressKey(0, 7);
    checkOutput("glitchStart", int'(level), 11);
    tick(260);
    found   = 1'b0;
    prevOut = ledOut;
    for (int i = 0; i < 600 && !found; i++) begin
      tick(1);
      if (prevOut == 8'h00 && ledOut == 8'hFF) found = 1'b1;
      else prevOut = ledOut;
    end
    if (!found) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL periodStart: actual=no rising edge expected=rising edge within 600 cycles");
    end else begin
      tick(97);
      keyUp = 1'b0;
      cntA  = 0;
      cntB  = 0;
      for (int j = 98; j < 768; j++) begin
        tick(1);
        if (j >= 256 && j < 512 && ledOut == 8'hFF) cntA++;
        if (j >= 512 && ledOut == 8'hFF) cntB++;
        if (j == 354) checkOutput("levelBeforeEdge", int'(level), 11);
        if (j == 355) checkOutput("levelAtCnt100", int'(level), 12);
      end
      checkOutput("periodKeepsOldDuty", cntA, 187);
      checkOutput("periodNewDuty", cntB, 204);
      keyUp = 1'b1;
      tick(HOLD);
    end
    expLevel = 12;

`ifdef LED_BREATH_EN
    begin
      int  modelLvl;
      bit  modelUp;
      int  changes;
      int  lastC;
      logic [3:0] prevLvl;

      pressKey(0, 2);
      checkOutput("breathStart", int'(level), 14);
      keyMode  = 1'b0;
      modelLvl = 14;
      modelUp  = 1'b1;
      changes  = 0;
      lastC    = 0;
      prevLvl  = level;
      for (int c = 1; c < 6000 && changes < 17; c++) begin
        tick(1);
        if (c == 300) keyMode = 1'b1;
        if (level != prevLvl) begin
          if (modelUp) begin
            modelLvl++;
            if (modelLvl == 15) modelUp = 1'b0;
          end else begin
            modelLvl--;
            if (modelLvl == 0) modelUp = 1'b1;
          end
          checkOutput("breathLevel", int'(level), modelLvl);
          if (changes > 0) checkOutput("breathInterval", c - lastC, 256);
          lastC   = c;
          prevLvl = level;
          changes++;
        end
      end
      checkOutput("breathSteps", changes, 17);
      // Mode press lands 258 cycles later, just after the next step to 2
      pressKey(2, 1);
      tick(DEB * 4);
      checkOutput("breathFrozen", int'(level), 2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
